axis_packet_fifo: RTL

AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

---
 rtl/axi_pkg.sv | 32 +++
 rtl/axis_fifo_ram.sv | 44 ++++
 rtl/axis_packet_fifo.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// axi_pkg : shared AXI-Stream widths, beat layout, FSM states, sizing helpers
// Revision : 1.0
// ============================================================================
package axi_pkg;

  localparam int AXI_DATA_SIZE = 32;
  localparam int AXI_ID_SIZE   = 8;

  typedef struct packed {
    logic [AXI_DATA_SIZE-1:0] data;
    logic [AXI_ID_SIZE-1:0]   id;
    logic                     last;
  } axis_beat_t;

  typedef enum logic [0:0] {
    PASS = 1'b0,
    DROP = 1'b1
  } pkt_state_e;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int beat_width(input int data_size, input int id_size);
    return data_size + id_size + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_fifo_ram.sv
`default_nettype none
// ============================================================================
// axis_fifo_ram : simple dual-port RAM with a registered, resettable read port
// Revision : 1.0
// ============================================================================
module axis_fifo_ram
  import axi_pkg::*;
#(
  parameter int WIDTH     = 41,
  parameter int DEPTH     = 16,
  parameter int ADDR_SIZE = ptr_width(DEPTH) - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register doubles as the stream output register, so it holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/axis_packet_fifo.sv
`default_nettype none
// ============================================================================
// axis_packet_fifo : store-and-forward AXI-Stream packet FIFO with oversize drop
// Revision : 1.0
// ============================================================================
module axis_packet_fifo
  import axi_pkg::*;
#(
  parameter int DATA_SIZE = AXI_DATA_SIZE,
  parameter int ID_SIZE   = AXI_ID_SIZE,
  parameter int DEPTH     = 16
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       s_t_valid,
  input  logic                       s_t_last,
  input  logic [DATA_SIZE-1:0]       s_t_data,
  input  logic [ID_SIZE-1:0]         s_t_id,
  output logic                       s_t_ready,
  output logic                       m_t_valid,
  output logic                       m_t_last,
  output logic [DATA_SIZE-1:0]       m_t_data,
  output logic [ID_SIZE-1:0]         m_t_id,
  input  logic                       m_t_ready,
  output logic [ptr_width(DEPTH)-1:0] pkt_count,
  output logic                       drop_pulse
);

  localparam int              PW        = ptr_width(DEPTH);
  localparam int              AW        = PW - 1;
  localparam int              BW        = beat_width(DATA_SIZE, ID_SIZE);
  localparam logic [PW-1:0]   DEPTH_PTR = PW'(DEPTH);
  localparam logic [PW-1:0]   PTR_ONE   = PW'(1);

  // Same field order as axis_beat_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_SIZE-1:0] data;
    logic [ID_SIZE-1:0]   id;
    logic                 last;
  } beat_t;

  pkt_state_e    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] cm_ptr_q, cm_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] pkt_count_q, pkt_count_d;
  logic          m_valid_q, m_valid_d;
  logic          drop_pulse_q, drop_pulse_d;

  logic [PW-1:0] used_beats, wr_inc;
  logic          full, s_accept, m_read, load, wr_en, commit;
  beat_t         wr_beat, rd_beat;

  assign wr_beat = '{data: s_t_data, id: s_t_id, last: s_t_last};

  always_comb begin
    // rd_ptr counts beats consumed downstream, so the beat held in the output register still occupies space.
    used_beats = wr_ptr_q - rd_ptr_q;
    full       = (used_beats == DEPTH_PTR);
    s_t_ready  = !areset && ((state_q == DROP) || !full);
    s_accept   = s_t_valid && s_t_ready;
    m_read     = m_valid_q && m_t_ready;
    wr_inc     = wr_ptr_q + PTR_ONE;
    rd_ptr_d   = m_read ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    load       = (cm_ptr_q != rd_ptr_d) && (!m_valid_q || m_t_ready);

    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cm_ptr_d     = cm_ptr_q;
    drop_pulse_d = 1'b0;
    wr_en        = 1'b0;
    commit       = 1'b0;

    if (s_accept) begin
      if (state_q == DROP) begin
        if (s_t_last) begin
          state_d = PASS;
        end
      end else if (((wr_inc - rd_ptr_q) == DEPTH_PTR) && (cm_ptr_q == rd_ptr_q)) begin
        // The open packet alone would fill the FIFO and can never drain: discard it.
        wr_ptr_d     = cm_ptr_q;
        drop_pulse_d = 1'b1;
        if (!s_t_last) begin
          state_d = DROP;
        end
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_inc;
        if (s_t_last) begin
          cm_ptr_d = wr_inc;
          commit   = 1'b1;
        end
      end
    end

    m_valid_d = load ? 1'b1 : (m_read ? 1'b0 : m_valid_q);

    case ({commit, m_read && rd_beat.last})
      2'b10:   pkt_count_d = pkt_count_q + PTR_ONE;
      2'b01:   pkt_count_d = pkt_count_q - PTR_ONE;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= PASS;
      wr_ptr_q     <= '0;
      cm_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pkt_count_q  <= '0;
      m_valid_q    <= 1'b0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cm_ptr_q     <= cm_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_count_q  <= pkt_count_d;
      m_valid_q    <= m_valid_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  axis_fifo_ram #(
    .WIDTH     (BW),
    .DEPTH     (DEPTH),
    .ADDR_SIZE (AW)
  ) u_ram (
    .clk     (aclk),
    .rst     (areset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_beat),
    .rd_en   (load),
    .rd_addr (rd_ptr_d[AW-1:0]),
    .rd_data (rd_beat)
  );

  assign m_t_valid  = m_valid_q;
  assign m_t_data   = rd_beat.data;
  assign m_t_id     = rd_beat.id;
  assign m_t_last   = rd_beat.last;
  assign pkt_count  = pkt_count_q;
  assign drop_pulse = drop_pulse_q;

endmodule
`default_nettype wire
